// File: rtl/charging_pkg.sv
// Shared types and constants for the coin acceptor and the charging station controller.
//   acc_state_t      : coin acceptor FSM state encoding
//   coin_t           : coin code carried on the Coin bus
//   COIN_NONE        : coin code meaning "no coin"
//   MAX_VALID_PULSES : largest pulse count that maps to a valid coin
package charging_pkg;

   localparam int unsigned COIN_W           = 3;
   localparam int unsigned MAX_VALID_PULSES = 5;

   typedef logic [COIN_W-1:0] coin_t;

   localparam coin_t COIN_NONE = 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HIGH   = 3'd1,
      ST_GAP    = 3'd2,
      ST_EMIT   = 3'd3,
      ST_REJECT = 3'd4
   } acc_state_t;

   // A pulse count is a real coin only in the range 1..MAX_VALID_PULSES.
   function automatic logic coin_ok(input coin_t cnt);
      return (cnt != COIN_NONE) && (cnt <= COIN_W'(MAX_VALID_PULSES));
   endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle.
//   master : the acceptor (reads mech line and gating inputs, drives coin outputs)
//   slave  : the consumer / board side (drives mech line and gating, reads coin outputs)
interface coin_acceptor_if;
   import charging_pkg::*;

   logic  PulseIn;
   logic  ModeEnable;
   logic  Charging;
   coin_t Coin;
   logic  CoinValid;
   logic  Reject;
   logic  Jam;

   modport master (
      input  PulseIn, ModeEnable, Charging,
      output Coin, CoinValid, Reject, Jam
   );

   modport slave (
      output PulseIn, ModeEnable, Charging,
      input  Coin, CoinValid, Reject, Jam
   );

endinterface

// File: rtl/coin_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
//   Clk, nReset : clock, async active-low reset
//   raw         : asynchronous mech line
//   db          : debounced level
//   rise, fall  : one-cycle strobes, high in the first cycle db shows its new level
module coin_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic Clk,
   input  logic nReset,
   input  logic raw,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] stable_cnt;
   logic             flip_c;

   // Flip on the DEBOUNCE_CYCLES-th consecutive cycle the synchronised input disagrees with db.
   assign flip_c = (sync_q[1] != db) && (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         sync_q     <= 2'b00;
         stable_cnt <= '0;
         db         <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         if ((sync_q[1] == db) || flip_c) begin
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
         if (flip_c) begin
            db <= sync_q[1];
         end
         rise <= flip_c & sync_q[1];
         fall <= flip_c & ~sync_q[1];
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: turns the coin mech pulse train into a one-cycle coin code.
//   Clk, nReset : clock, async active-low reset
//   bus.PulseIn    : raw mech line (async)
//   bus.ModeEnable : acceptor enabled, sampled at end of a pulse train
//   bus.Charging   : station busy, sampled at end of a pulse train
//   bus.Coin       : coin code (pulse count), 0 unless CoinValid
//   bus.CoinValid  : one-cycle coin strobe
//   bus.Reject     : return solenoid drive, REJECT_CYCLES long
//   bus.Jam        : sticky jammed-mechanism flag
module coin_acceptor
   import charging_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES      = 32,
   parameter int unsigned HIGH_TIMEOUT    = 128,
   parameter int unsigned REJECT_CYCLES   = 16
) (
   input  logic            Clk,
   input  logic            nReset,
   coin_acceptor_if.master bus
);

   localparam int unsigned TMR_A   = (GAP_CYCLES > HIGH_TIMEOUT) ? GAP_CYCLES : HIGH_TIMEOUT;
   localparam int unsigned TMR_MAX = (TMR_A > REJECT_CYCLES) ? TMR_A : REJECT_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   acc_state_t       state_q, state_d;
   logic [TMR_W-1:0] timer_q;
   coin_t            count_q;

   logic  db, db_rise, db_fall;
   logic  gap_done_c, high_done_c, rej_done_c;
   coin_t coin_d;
   logic  valid_d, reject_d, jam_d;

   coin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .Clk    (Clk),
      .nReset (nReset),
      .raw    (bus.PulseIn),
      .db     (db),
      .rise   (db_rise),
      .fall   (db_fall)
   );

   // timer_q counts completed cycles in the current state, so "== N-1" ends the N-th cycle.
   assign gap_done_c  = (timer_q == TMR_W'(GAP_CYCLES - 1));
   assign high_done_c = (timer_q == TMR_W'(HIGH_TIMEOUT - 1)) && db;
   assign rej_done_c  = (timer_q == TMR_W'(REJECT_CYCLES - 1));

   // State register
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (db_rise) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            if (db_fall)          state_d = ST_GAP;
            else if (high_done_c) state_d = ST_REJECT;
         end
         ST_GAP: begin
            // Gating inputs only matter on the cycle the gap expires.
            if (gap_done_c) begin
               if (coin_ok(count_q) && bus.ModeEnable && !bus.Charging) state_d = ST_EMIT;
               else                                                      state_d = ST_REJECT;
            end else if (db_rise) begin
               state_d = ST_HIGH;
            end
         end
         ST_EMIT: begin
            state_d = ST_IDLE;
         end
         ST_REJECT: begin
            if (rej_done_c) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic, evaluated on the next state so the registered outputs align with it
   always_comb begin
      coin_d   = COIN_NONE;
      valid_d  = 1'b0;
      reject_d = 1'b0;
      jam_d    = bus.Jam;
      if (state_d == ST_EMIT) begin
         coin_d  = count_q;
         valid_d = 1'b1;
      end
      if (state_d == ST_REJECT) begin
         reject_d = 1'b1;
      end
      if ((state_q == ST_HIGH) && (state_d == ST_REJECT)) begin
         jam_d = 1'b1;
      end
   end

   // Output registers
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         bus.Coin      <= COIN_NONE;
         bus.CoinValid <= 1'b0;
         bus.Reject    <= 1'b0;
         bus.Jam       <= 1'b0;
      end else begin
         bus.Coin      <= coin_d;
         bus.CoinValid <= valid_d;
         bus.Reject    <= reject_d;
         bus.Jam       <= jam_d;
      end
   end

   // State timer and saturating pulse counter
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         timer_q <= '0;
         count_q <= COIN_NONE;
      end else begin
         if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + TMR_W'(1);
         end

         if (state_d == ST_IDLE) begin
            count_q <= COIN_NONE;
         end else if ((state_q == ST_IDLE) && (state_d == ST_HIGH)) begin
            count_q <= 3'd1;
         end else if ((state_q == ST_GAP) && (state_d == ST_HIGH) && (count_q != 3'd7)) begin
            count_q <= count_q + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: expected coin/reject events are queued as
// stimulus is driven and matched as the acceptor produces them.
module tb_coin_acceptor;
   import charging_pkg::*;

   localparam int EV_REJECT   = 8;
   localparam int REJ_LEN     = 16;
   localparam int FALL_TO_VAL = 2 + 4 + 32 + 1;

   logic clk = 1'b0;
   logic n_reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   coin_acceptor_if bus();

   coin_acceptor dut (
      .Clk    (clk),
      .nReset (n_reset),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int lat_ref = -1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Output monitor
   logic prev_valid = 1'b0;
   logic prev_rej   = 1'b0;
   int   valid_len  = 0;
   int   rej_len    = 0;
   int   ev;

   always @(negedge clk) begin
      if (!n_reset) begin
         prev_valid = 1'b0;
         prev_rej   = 1'b0;
         valid_len  = 0;
         rej_len    = 0;
      end else begin
         if (bus.CoinValid) begin
            if (!prev_valid) begin
               ev = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
               check("coin_event", int'(bus.Coin), ev);
               check("coin_vs_reject", int'(bus.Reject), 0);
               if (lat_ref >= 0) begin
                  check("fall_to_valid_latency", cyc - lat_ref, FALL_TO_VAL);
                  lat_ref = -1;
               end
            end
            valid_len++;
         end else begin
            if (prev_valid) check("valid_width", valid_len, 1);
            valid_len = 0;
            check("coin_zero_when_invalid", int'(bus.Coin), 0);
         end

         if (bus.Reject) begin
            if (!prev_rej) begin
               ev = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
               check("reject_event", EV_REJECT, ev);
            end
            rej_len++;
         end else begin
            if (prev_rej) check("reject_len", rej_len, REJ_LEN);
            rej_len = 0;
         end

         prev_valid = bus.CoinValid;
         prev_rej   = bus.Reject;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      bus.PulseIn = 1'b1;
      tick(hi);
      bus.PulseIn = 1'b0;
      tick(lo);
   endtask

   // Wait for all queued events to be produced and the outputs to go quiet.
   task automatic settle();
      int n = 0;
      while ((exp_q.size() != 0 || bus.Reject || bus.CoinValid) && n < 400) begin
         tick(1);
         n++;
      end
      check("events_drained", exp_q.size(), 0);
      tick(10);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_coin"},   int'(bus.Coin), 0);
      check({tag, "_valid"},  int'(bus.CoinValid), 0);
      check({tag, "_reject"}, int'(bus.Reject), 0);
      check({tag, "_jam"},    int'(bus.Jam), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.PulseIn    = 1'b0;
      bus.ModeEnable = 1'b1;
      bus.Charging   = 1'b0;
      n_reset        = 1'b0;
      tick(3);
      check_all_zero("reset");
      n_reset = 1'b1;
      tick(5);

      // Single pulse with latency check
      bus.PulseIn = 1'b1;
      tick(20);
      bus.PulseIn = 1'b0;
      lat_ref = cyc;
      exp_q.push_back(1);
      settle();

      // Five pulses -> one coin of 5
      exp_q.push_back(5);
      for (int i = 0; i < 5; i++) pulse(20, 10);
      settle();

      // Six pulses -> reject
      exp_q.push_back(EV_REJECT);
      for (int i = 0; i < 6; i++) pulse(20, 10);
      settle();

      // Three pulses -> coin 3
      exp_q.push_back(3);
      for (int i = 0; i < 3; i++) pulse(25, 12);
      settle();

      // Station busy at gap exit -> reject
      bus.Charging = 1'b1;
      exp_q.push_back(EV_REJECT);
      pulse(20, 0);
      settle();
      bus.Charging = 1'b0;

      // Acceptor disabled at gap exit -> reject
      bus.ModeEnable = 1'b0;
      exp_q.push_back(EV_REJECT);
      pulse(20, 0);
      settle();
      bus.ModeEnable = 1'b1;

      // Gating inputs bad only during the high phase -> accepted
      bus.Charging   = 1'b1;
      bus.ModeEnable = 1'b0;
      bus.PulseIn    = 1'b1;
      tick(20);
      bus.PulseIn    = 1'b0;
      bus.Charging   = 1'b0;
      bus.ModeEnable = 1'b1;
      exp_q.push_back(1);
      settle();

      // Short glitch -> nothing
      pulse(2, 80);
      settle();
      check("glitch_no_jam", int'(bus.Jam), 0);

      // Stuck-high mech -> jam + reject, jam sticky
      exp_q.push_back(EV_REJECT);
      bus.PulseIn = 1'b1;
      tick(200);
      bus.PulseIn = 1'b0;
      tick(50);
      check("jam_set", int'(bus.Jam), 1);
      settle();
      check("jam_sticky", int'(bus.Jam), 1);

      // Reset mid-train: outputs (including jam) drop immediately
      bus.PulseIn = 1'b1;
      tick(15);
      #2 n_reset = 1'b0;
      #1 check_all_zero("reset_mid_train");
      bus.PulseIn = 1'b0;
      tick(3);
      n_reset = 1'b1;
      tick(5);
      exp_q.push_back(1);
      pulse(20, 0);
      settle();

      // Reset mid-reject
      bus.Charging = 1'b1;
      exp_q.push_back(EV_REJECT);
      pulse(20, 0);
      n = 0;
      while (!bus.Reject && n < 200) begin
         tick(1);
         n++;
      end
      check("reject_seen", int'(bus.Reject), 1);
      tick(5);
      #2 n_reset = 1'b0;
      #1 check_all_zero("reset_mid_reject");
      bus.Charging = 1'b0;
      tick(3);
      n_reset = 1'b1;
      tick(5);
      exp_q.push_back(1);
      pulse(20, 0);
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
